// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FETCH/DECODE/EXEC control unit for the 9-bit CPU
module multicycle_sequencer #(
    parameter int              PC_W     = 10,
    parameter int              MEM_LAT  = 1,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [8:0]      HALT_OP  = 9'h1FF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      instr_i,
    input  logic            reg_zero,
    output logic            lit,
    output logic            mov,
    output logic            alu_en,
    output logic            load_en,
    output logic            stor_en,
    output logic            lit_nibble,
    output logic [3:0]      lit_val,
    output logic            mem_sel,
    output logic [3:0]      reg_src,
    output logic [3:0]      reg_dst,
    output logic [6:0]      alu_op,
    output logic            busy,
    output logic            done
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_DECODE   = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_MEM_WAIT = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    localparam int              CNT_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    logic [2:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [8:0]       ir_q, ir_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [3:0]       src_q, src_d, dst_q, dst_d;
    logic             msel_q, msel_d;

    logic is_halt, is_lit, is_mov, is_mem, is_br, is_jmp, is_alu, br_taken;

    assign is_halt  = (ir_q == HALT_OP);
    assign is_lit   = ~ir_q[8] & (ir_q[6:5] == 2'b00);
    assign is_mov   = ~ir_q[8] & (ir_q[6:5] != 2'b00);
    assign is_mem   = (ir_q[8:5] == 4'b1000);
    assign is_br    = (ir_q[8:5] == 4'b1001);
    assign is_jmp   = (ir_q[8:5] == 4'b1010);
    assign is_alu   = (ir_q[8:7] == 2'b11) & ~is_halt;
    assign br_taken = ir_q[4] ? ~reg_zero : reg_zero;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        src_d   = src_q;
        dst_d   = dst_q;
        msel_d  = msel_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d    = instr_i;
                state_d = ST_EXEC;
                // Register fields are latched with the IR so they are valid for all of EXEC
                // and keep the last relevant decode afterwards.
                if (instr_i != HALT_OP) begin
                    if (!instr_i[8]) begin
                        if (instr_i[6:5] == 2'b00) begin
                            dst_d = instr_i[3:0];
                        end else begin
                            dst_d = instr_i[7:4];
                            src_d = instr_i[3:0];
                        end
                    end else if (instr_i[7:5] == 3'b000) begin
                        msel_d = instr_i[3];
                        if (instr_i[4]) src_d = {1'b0, instr_i[2:0]};
                        else            dst_d = {1'b0, instr_i[2:0]};
                    end else if (instr_i[7:5] == 3'b001) begin
                        src_d = instr_i[3:0];
                    end else if (instr_i[7]) begin
                        dst_d = instr_i[3:0];
                    end
                end
            end
            ST_EXEC: begin
                if (is_halt) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = pc_q + PC_W'(1);
                    if (is_br && br_taken) begin
                        pc_d = pc_q + PC_W'(2);
                    end else if (is_jmp) begin
                        pc_d = pc_q + {{(PC_W-5){ir_q[4]}}, ir_q[4:0]};
                    end else if (is_mem && (MEM_LAT > 1)) begin
                        state_d = ST_MEM_WAIT;
                        wait_d  = WAIT_INIT;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (wait_q == '0) state_d = ST_FETCH;
                else              wait_d  = wait_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            wait_q  <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            msel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            msel_q  <= msel_d;
        end
    end

    logic in_exec, in_mem;
    assign in_exec = (state_q == ST_EXEC);
    assign in_mem  = in_exec | (state_q == ST_MEM_WAIT);

    assign imem_addr  = pc_q;
    assign lit        = in_exec & is_lit;
    assign mov        = in_exec & is_mov;
    assign alu_en     = in_exec & is_alu;
    assign load_en    = in_mem & is_mem & ~ir_q[4];
    assign stor_en    = in_mem & is_mem & ir_q[4];
    assign lit_nibble = ir_q[4];
    assign lit_val    = ir_q[3:0];
    assign alu_op     = ir_q[6:0];
    assign mem_sel    = msel_q;
    assign reg_src    = src_q;
    assign reg_dst    = dst_q;
    assign busy       = (state_q == ST_FETCH) | (state_q == ST_DECODE) | in_mem;
    assign done       = (state_q == ST_DONE);
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized ISA-level check of multicycle_sequencer
module tb_multicycle_sequencer;
    localparam int         PC_W    = 10;
    localparam int         MEM_LAT = 3;
    localparam int         NPC     = 1 << PC_W;
    localparam logic [8:0] HALT    = 9'h1FF;
    localparam logic [8:0] NOP     = 9'h170;

    logic            clk = 1'b0;
    logic            rst_n, start, reg_zero;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      instr_i = '0;
    logic            lit, mov, alu_en, load_en, stor_en, lit_nibble, mem_sel, busy, done;
    logic [3:0]      lit_val, reg_src, reg_dst;
    logic [6:0]      alu_op;

    multicycle_sequencer #(.PC_W(PC_W), .MEM_LAT(MEM_LAT), .RESET_PC('0), .HALT_OP(HALT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr), .instr_i(instr_i),
        .reg_zero(reg_zero), .lit(lit), .mov(mov), .alu_en(alu_en), .load_en(load_en),
        .stor_en(stor_en), .lit_nibble(lit_nibble), .lit_val(lit_val), .mem_sel(mem_sel),
        .reg_src(reg_src), .reg_dst(reg_dst), .alu_op(alu_op), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [8:0] rom [NPC];
    always @(posedge clk) instr_i <= rom[imem_addr];

    int n_vec = 0;
    int n_err = 0;
    int mpc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (pc model %0d, t=%0t)", tag, got, exp, mpc, $time);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {lit, mov, alu_en, load_en, stor_en};
    endfunction

    // One instruction per iteration, checked against the ISA rules directly.
    task automatic run_prog(input bit do_start, input int max_instr, output bit halted);
        logic [8:0] ins;
        logic [4:0] exp_sb;
        int         npc, off;
        halted = 1'b0;
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            mpc   = 0;
            chk("done_cleared", {31'd0, done}, 32'd0);
        end
        for (int k = 0; k < max_instr; k++) begin
            chk("fetch_addr", {22'd0, imem_addr}, mpc);
            chk("fetch_busy", {31'd0, busy}, 32'd1);
            chk("fetch_strb", {27'd0, strobes()}, 32'd0);
            @(negedge clk);
            chk("dec_strb", {27'd0, strobes()}, 32'd0);
            reg_zero = 1'($urandom);
            start    = 1'($urandom);
            @(negedge clk);
            start = 1'b0;
            ins   = rom[mpc];
            npc   = (mpc + 1) % NPC;
            exp_sb = 5'b0;
            if (ins == HALT) begin
                exp_sb = 5'b0;
            end else if (!ins[8]) begin
                if (ins[6:5] == 2'b00) begin
                    exp_sb = 5'b10000;
                    chk("lit_nib", {31'd0, lit_nibble}, {31'd0, ins[4]});
                    chk("lit_val", {28'd0, lit_val}, {28'd0, ins[3:0]});
                    chk("lit_dst", {28'd0, reg_dst}, {28'd0, ins[3:0]});
                end else begin
                    exp_sb = 5'b01000;
                    chk("mov_dst", {28'd0, reg_dst}, {28'd0, ins[7:4]});
                    chk("mov_src", {28'd0, reg_src}, {28'd0, ins[3:0]});
                end
            end else if (ins[7]) begin
                exp_sb = 5'b00100;
                chk("alu_op", {25'd0, alu_op}, {25'd0, ins[6:0]});
                chk("alu_dst", {28'd0, reg_dst}, {28'd0, ins[3:0]});
            end else begin
                case (ins[6:5])
                    2'b00: exp_sb = ins[4] ? 5'b00001 : 5'b00010;
                    2'b01: begin
                        chk("br_src", {28'd0, reg_src}, {28'd0, ins[3:0]});
                        if (ins[4] ? !reg_zero : reg_zero) npc = (mpc + 2) % NPC;
                    end
                    2'b10: begin
                        off = int'(ins[4:0]);
                        if (off > 15) off -= 32;
                        npc = (mpc + off + NPC) % NPC;
                    end
                    default: ;
                endcase
            end
            for (int c = 0; c < ((exp_sb[1] | exp_sb[0]) ? MEM_LAT : 1); c++) begin
                if (c > 0) @(negedge clk);
                chk("exec_strb", {27'd0, strobes()}, {27'd0, exp_sb});
                chk("exec_busy", {31'd0, busy}, 32'd1);
                if (exp_sb[1] | exp_sb[0]) begin
                    chk("mem_sel", {31'd0, mem_sel}, {31'd0, ins[3]});
                    if (ins[4]) chk("st_src", {28'd0, reg_src}, {29'd0, ins[2:0]});
                    else        chk("ld_dst", {28'd0, reg_dst}, {29'd0, ins[2:0]});
                end
            end
            @(negedge clk);
            if (ins == HALT) begin
                halted = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    chk("done_held", {31'd0, done}, 32'd1);
                    chk("done_idle", {31'd0, busy}, 32'd0);
                    @(negedge clk);
                end
                return;
            end
            mpc = npc;
        end
    endtask

    bit h;

    initial begin
        rst_n = 1'b0; start = 1'b0; reg_zero = 1'b0;
        for (int i = 0; i < NPC; i++) rom[i] = NOP;
        repeat (3) @(negedge clk);
        chk("rst_addr", {22'd0, imem_addr}, 32'd0);
        chk("rst_strb", {27'd0, strobes()}, 32'd0);
        chk("rst_flags", {30'd0, busy, done}, 32'd0);
        chk("rst_fields", {8'd0, lit_nibble, lit_val, mem_sel, reg_src, reg_dst, alu_op}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_flags", {30'd0, busy, done}, 32'd0);

        rom[0] = 9'h01A; rom[1] = 9'h05A; rom[2] = HALT;
        run_prog(1'b1, 10, h);
        chk("prog_a_halt", {31'd0, h}, 32'd1);

        for (int i = 0; i < NPC; i++) begin
            rom[i] = 9'($urandom_range(0, 511));
            if (rom[i] == HALT) rom[i] = NOP;
        end
        rom[0]    = 9'h143;
        rom[3]    = 9'h150;
        rom[1011] = 9'h11D;
        rom[1012] = 9'h1B3;
        rom[1013] = 9'h122;
        rom[1014] = 9'h14F;
        rom[1023] = 9'h14F;
        run_prog(1'b1, 400, h);
        for (int i = 0; i < NPC; i++) rom[i] = HALT;
        run_prog(1'b0, 2, h);
        chk("prog_b_halt", {31'd0, h}, 32'd1);

        rom[0] = 9'h102;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ld_fetch", {22'd0, imem_addr}, 32'd0);
        repeat (3) @(negedge clk);
        chk("ld_wait", {31'd0, load_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ld_abort", {27'd0, strobes()}, 32'd0);
        chk("ld_abort_flags", {30'd0, busy, done}, 32'd0);
        chk("ld_abort_pc", {22'd0, imem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst", {27'd0, strobes()}, 32'd0);
        chk("post_rst_flags", {30'd0, busy, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
